// File: rtl/matmul_sequencer.sv
// Matrix-multiply processing engine: issues A/B reads, accumulates products and
// writes each C element, then signals completion back to the state controller.
module matmul_sequencer #(
  parameter int unsigned N      = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned AW     = 4,
  parameter int unsigned ACC_W  = 18
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic [1:0]        status,
  output logic [AW-1:0]     a_addr,
  output logic [AW-1:0]     b_addr,
  output logic              rd_en,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  output logic [AW-1:0]     c_addr,
  output logic [ACC_W-1:0]  c_wdata,
  output logic              c_we,
  output logic              busy,
  output logic              process_finish
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PW = 2 * DATA_W;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     i_q, i_d, j_q, j_d, k_q, k_d;
  logic              flush_q, flush_d;
  logic              v1_q, v1_d, first1_q, first1_d, last1_q, last1_d;
  logic [AW-1:0]     caddr1_q, caddr1_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [AW-1:0]     a_addr_q, a_addr_d, b_addr_q, b_addr_d, c_addr_q, c_addr_d;
  logic [ACC_W-1:0]  c_wdata_q, c_wdata_d;
  logic              rd_en_q, rd_en_d, c_we_q, c_we_d;
  logic              busy_q, busy_d, finish_q, finish_d;
  logic [PW-1:0]     prod_c;
  logic              abort_c;

  function automatic logic [AW-1:0] lin(input logic [CW-1:0] row, input logic [CW-1:0] col);
    return AW'(row) * AW'(N) + AW'(col);
  endfunction

  assign prod_c  = {{DATA_W{1'b0}}, data_a} * {{DATA_W{1'b0}}, data_b};
  assign abort_c = ((state_q == S_RUN) || (state_q == S_FLUSH)) &&
                   ((status == 2'b00) || (status == 2'b10));

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    flush_d   = flush_q;
    acc_d     = acc_q;
    a_addr_d  = a_addr_q;
    b_addr_d  = b_addr_q;
    c_addr_d  = c_addr_q;
    c_wdata_d = c_wdata_q;
    rd_en_d   = 1'b0;
    c_we_d    = 1'b0;
    // Tags of the issue on the bus travel with its returning data
    v1_d      = rd_en_q;
    first1_d  = (k_q == '0);
    last1_d   = (k_q == LAST);
    caddr1_d  = lin(i_q, j_q);

    if (v1_q) begin
      acc_d = (first1_q ? '0 : acc_q) + ACC_W'(prod_c);
      if (last1_q) begin
        c_we_d    = 1'b1;
        c_wdata_d = acc_d;
        c_addr_d  = caddr1_q;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (status == 2'b01) begin
          state_d  = S_RUN;
          i_d      = '0;
          j_d      = '0;
          k_d      = '0;
          rd_en_d  = 1'b1;
          a_addr_d = '0;
          b_addr_d = '0;
        end
      end
      S_RUN: begin
        if ((i_q == LAST) && (j_q == LAST) && (k_q == LAST)) begin
          state_d = S_FLUSH;
          flush_d = 1'b0;
        end else begin
          k_d = (k_q == LAST) ? '0 : k_q + CW'(1);
          if (k_q == LAST) begin
            j_d = (j_q == LAST) ? '0 : j_q + CW'(1);
            if (j_q == LAST) i_d = i_q + CW'(1);
          end
          rd_en_d  = 1'b1;
          a_addr_d = lin(i_d, k_d);
          b_addr_d = lin(k_d, j_d);
        end
      end
      S_FLUSH: begin
        flush_d = 1'b1;
        if (flush_q) state_d = S_DONE;
      end
      S_DONE: begin
        if (status == 2'b00) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort kills the issue stream and any write still in flight
    if (abort_c) begin
      state_d = S_IDLE;
      rd_en_d = 1'b0;
      v1_d    = 1'b0;
      c_we_d  = 1'b0;
    end

    busy_d   = (state_d == S_RUN) || (state_d == S_FLUSH);
    finish_d = (state_d == S_DONE);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      flush_q   <= 1'b0;
      v1_q      <= 1'b0;
      first1_q  <= 1'b0;
      last1_q   <= 1'b0;
      caddr1_q  <= '0;
      acc_q     <= '0;
      a_addr_q  <= '0;
      b_addr_q  <= '0;
      c_addr_q  <= '0;
      c_wdata_q <= '0;
      rd_en_q   <= 1'b0;
      c_we_q    <= 1'b0;
      busy_q    <= 1'b0;
      finish_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      flush_q   <= flush_d;
      v1_q      <= v1_d;
      first1_q  <= first1_d;
      last1_q   <= last1_d;
      caddr1_q  <= caddr1_d;
      acc_q     <= acc_d;
      a_addr_q  <= a_addr_d;
      b_addr_q  <= b_addr_d;
      c_addr_q  <= c_addr_d;
      c_wdata_q <= c_wdata_d;
      rd_en_q   <= rd_en_d;
      c_we_q    <= c_we_d;
      busy_q    <= busy_d;
      finish_q  <= finish_d;
    end
  end

  assign a_addr         = a_addr_q;
  assign b_addr         = b_addr_q;
  assign c_addr         = c_addr_q;
  assign c_wdata        = c_wdata_q;
  assign rd_en          = rd_en_q;
  assign c_we           = c_we_q;
  assign busy           = busy_q;
  assign process_finish = finish_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: synchronous-read A/B memories, reference C from
// plain triple-loop arithmetic, cycle-accurate checks of reads, writes and handshake.
module tb_matmul_sequencer;

  localparam int unsigned N      = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned AW     = 4;
  localparam int unsigned ACC_W  = 18;
  localparam int NN  = N * N;
  localparam int NNN = N * N * N;

  logic              clock = 1'b0;
  logic              rst_n;
  logic [1:0]        status;
  logic [AW-1:0]     a_addr, b_addr, c_addr;
  logic              rd_en, c_we, busy, process_finish;
  logic [DATA_W-1:0] data_a, data_b;
  logic [ACC_W-1:0]  c_wdata;

  logic [DATA_W-1:0] mem_a [NN];
  logic [DATA_W-1:0] mem_b [NN];
  int                cref  [NN];
  int                n_checks = 0;
  int                n_fail   = 0;

  matmul_sequencer #(.N(N), .DATA_W(DATA_W), .AW(AW), .ACC_W(ACC_W)) dut (
    .clock(clock), .rst_n(rst_n), .status(status),
    .a_addr(a_addr), .b_addr(b_addr), .rd_en(rd_en),
    .data_a(data_a), .data_b(data_b),
    .c_addr(c_addr), .c_wdata(c_wdata), .c_we(c_we),
    .busy(busy), .process_finish(process_finish)
  );

  always #5 clock = ~clock;

  // Synchronous-read memories: data valid the cycle after rd_en
  always @(posedge clock) begin
    if (rd_en) begin
      data_a <= mem_a[a_addr];
      data_b <= mem_b[b_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load(input int mode);
    for (int idx = 0; idx < NN; idx++) begin
      case (mode)
        0: begin
          mem_a[idx] = DATA_W'((idx / N == idx % N) ? 1 : 0);
          mem_b[idx] = DATA_W'(idx);
        end
        1: begin
          mem_a[idx] = 8'hFF;
          mem_b[idx] = 8'hFF;
        end
        default: begin
          mem_a[idx] = DATA_W'($urandom_range(0, 255));
          mem_b[idx] = DATA_W'($urandom_range(0, 255));
        end
      endcase
    end
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        cref[r*N+c] = 0;
        for (int m = 0; m < N; m++)
          cref[r*N+c] += int'(mem_a[r*N+m]) * int'(mem_b[m*N+c]);
      end
  endtask

  // Starts a run from IDLE; abort_at >= 0 drops status so the edge opening that cycle sees 00
  task automatic run_check(input string name, input int abort_at);
    int  nw, nrd, expw, ri, rj, rk;
    bit  done;
    nw = 0; nrd = 0; done = 0;
    @(negedge clock);
    status = 2'b01;
    for (int r = 0; r < NNN + 20 && !done; r++) begin
      @(negedge clock);
      if (r == 0) chk($sformatf("%s start rd_en", name), rd_en, 1);
      if (r == 0) chk($sformatf("%s start busy", name), busy, 1);
      if (rd_en) begin
        ri = nrd / NN; rj = (nrd / N) % N; rk = nrd % N;
        chk($sformatf("%s rd%0d cycle", name, nrd), r, nrd);
        chk($sformatf("%s rd%0d addr", name, nrd), {a_addr, b_addr},
            {AW'(ri * N + rk), AW'(rk * N + rj)});
        nrd++;
      end
      if (c_we) begin
        chk($sformatf("%s wr%0d addr", name, nw), c_addr, nw);
        chk($sformatf("%s wr%0d data", name, nw), c_wdata, (nw < NN) ? cref[nw] : -1);
        chk($sformatf("%s wr%0d cycle", name, nw), r, N * (nw + 1) + 1);
        nw++;
      end
      if (abort_at >= 0) begin
        if (r == abort_at - 1) status = 2'b00;
        if (r == abort_at) chk($sformatf("%s abort idle", name), {rd_en, busy, c_we}, 0);
        if (process_finish) chk($sformatf("%s abort finish", name), process_finish, 0);
        if (r == abort_at + 3) done = 1;
      end else if (process_finish) begin
        chk($sformatf("%s finish cycle", name), r, NNN + 2);
        chk($sformatf("%s done busy", name), busy, 0);
        done = 1;
      end
    end
    if (!done) chk($sformatf("%s timeout", name), 0, 1);
    expw = 0;
    for (int e = 0; e < NN; e++)
      if (abort_at < 0 || N * (e + 1) + 1 < abort_at) expw++;
    chk($sformatf("%s write count", name), nw, expw);
    chk($sformatf("%s read count", name), nrd, (abort_at < 0) ? NNN : abort_at);
  endtask

  task automatic handshake(input string name);
    status = 2'b11;
    repeat (3) begin
      @(negedge clock);
      chk($sformatf("%s hold11", name), {process_finish, busy, rd_en, c_we}, 4'b1000);
    end
    status = 2'b01;
    repeat (4) begin
      @(negedge clock);
      chk($sformatf("%s hold01", name), {process_finish, busy, rd_en, c_we}, 4'b1000);
    end
    status = 2'b00;
    @(negedge clock);
    chk($sformatf("%s release", name), process_finish, 0);
  endtask

  task automatic check_all_zero(input string name);
    chk(name, {a_addr, b_addr, c_addr, c_wdata, rd_en, c_we, busy, process_finish}, 0);
  endtask

  initial begin
    rst_n  = 1'b0;
    status = 2'b00;
    data_a = '0;
    data_b = '0;
    repeat (2) @(negedge clock);
    check_all_zero("reset outputs");
    rst_n = 1'b1;
    repeat (2) @(negedge clock);
    check_all_zero("idle outputs");

    load(0); run_check("identity", -1); handshake("identity");
    load(1); run_check("max", -1); handshake("max");
    for (int t = 0; t < 3; t++) begin
      load(2); run_check($sformatf("rand%0d", t), -1); handshake($sformatf("rand%0d", t));
    end

    // Illegal status in IDLE must not start anything
    status = 2'b10;
    repeat (4) begin
      @(negedge clock);
      chk("illegal idle", {rd_en, busy, process_finish}, 0);
    end
    status = 2'b00;
    @(negedge clock);

    load(2); run_check("abort", 6);
    load(2); run_check("after abort", -1); handshake("after abort");

    // Asynchronous reset in the middle of a run
    load(2);
    @(negedge clock);
    status = 2'b01;
    repeat (10) @(negedge clock);
    status = 2'b00;
    #2 rst_n = 1'b0;
    #1 check_all_zero("async reset");
    @(negedge clock);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("post reset idle", {rd_en, busy, c_we, process_finish}, 0);
    end
    load(2); run_check("after reset", -1); handshake("after reset");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
